// File: rtl/servo_ramp_sequencer.sv
// servo_ramp_sequencer
//   Memory-mapped slew-rate limiter for the servo PWM channels. The CPU stores
//   per-channel target duty values and a shared step size on the dmem bus.
//   Every TICK_DIV clocks, one shared step unit walks the channels round-robin.
//   On each visit it moves that channel's live duty toward its target by at
//   most one step.
//
// Ports
//   clock        system clock
//   reset        asynchronous, active-high
//   wren         store strobe
//   address_dmem store/load word address
//   data         store data (low DUTY_W bits used)
//   rd_data      registered read-back (live duty, step or busy), 1-cycle latency
//   rd_hit       registered: previous-cycle address selected a block register
//   duty_out     live duty values, channel k at [k*DUTY_W +: DUTY_W]
//   busy         busy[k] = live[k] != target[k]
module servo_ramp_sequencer #(
  parameter int NUM_CH       = 3,
  parameter int DUTY_W       = 10,
  parameter int TICK_DIV     = 50000,
  parameter int CH_BASE_ADDR = 11,
  parameter int STEP_ADDR    = 21,
  parameter int STATUS_ADDR  = 22,
  parameter int RESET_DUTY   = 0
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     wren,
  input  logic [11:0]              address_dmem,
  input  logic [31:0]              data,
  output logic [31:0]              rd_data,
  output logic                     rd_hit,
  output logic [NUM_CH*DUTY_W-1:0] duty_out,
  output logic [NUM_CH-1:0]        busy
);

  localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TICK_DIV - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(NUM_CH - 1);
  localparam logic [DUTY_W-1:0] DUTY_RST = DUTY_W'(RESET_DUTY);

  typedef enum logic {
    IDLE,
    UPDATE
  } state_t;

  logic [DUTY_W-1:0] target [NUM_CH];
  logic [DUTY_W-1:0] live   [NUM_CH];
  logic [DUTY_W-1:0] step;

  logic [CNT_W-1:0]  tick_cnt;
  logic              tick_wrap;
  state_t            state;
  logic [IDX_W-1:0]  idx;

  logic [NUM_CH-1:0] ch_sel;
  logic              step_sel;
  logic              status_sel;

  logic [DUTY_W-1:0] cur_live;
  logic [DUTY_W-1:0] cur_tgt;
  logic [DUTY_W-1:0] next_live;
  logic [DUTY_W:0]   sum_up;
  logic [DUTY_W:0]   lim_dn;

  // Upper store-data bits have no destination in this block.
  logic data_unused;
  assign data_unused = ^data[31:DUTY_W];

  assign tick_wrap = (tick_cnt == CNT_LAST);

  // Address decode shared by the store and read-back paths.
  always_comb begin
    ch_sel = '0;
    for (int unsigned k = 0; k < NUM_CH; k++) begin
      ch_sel[k] = (address_dmem == 12'(CH_BASE_ADDR + k));
    end
    step_sel   = (address_dmem == 12'(STEP_ADDR));
    status_sel = (address_dmem == 12'(STATUS_ADDR));
  end

  // Shared step unit. Comparisons are done one bit wider so that neither
  // live+step nor target+step can wrap; the downward case uses
  // live-step < target  <=>  live < target+step  to avoid underflow.
  always_comb begin
    cur_live = '0;
    cur_tgt  = '0;
    for (int unsigned k = 0; k < NUM_CH; k++) begin
      if (idx == IDX_W'(k)) begin
        cur_live = live[k];
        cur_tgt  = target[k];
      end
    end
    sum_up    = {1'b0, cur_live} + {1'b0, step};
    lim_dn    = {1'b0, cur_tgt} + {1'b0, step};
    next_live = cur_live;
    if (step == '0) begin
      next_live = cur_tgt;
    end else if (cur_live < cur_tgt) begin
      next_live = (sum_up >= {1'b0, cur_tgt}) ? cur_tgt : sum_up[DUTY_W-1:0];
    end else if (cur_live > cur_tgt) begin
      next_live = ({1'b0, cur_live} <= lim_dn) ? cur_tgt : (cur_live - step);
    end
  end

  // Tick scheduler and round-robin update pass.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      tick_cnt <= '0;
      state    <= IDLE;
      idx      <= '0;
      for (int unsigned k = 0; k < NUM_CH; k++) begin
        live[k] <= DUTY_RST;
      end
    end else begin
      tick_cnt <= tick_wrap ? '0 : tick_cnt + 1'b1;
      case (state)
        IDLE: begin
          if (tick_wrap) begin
            state <= UPDATE;
            idx   <= '0;
          end
        end
        UPDATE: begin
          for (int unsigned k = 0; k < NUM_CH; k++) begin
            if (idx == IDX_W'(k)) begin
              live[k] <= next_live;
            end
          end
          if (idx == IDX_LAST) begin
            state <= IDLE;
            idx   <= '0;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          idx   <= '0;
        end
      endcase
    end
  end

  // CPU-visible registers and registered read-back.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int unsigned k = 0; k < NUM_CH; k++) begin
        target[k] <= DUTY_RST;
      end
      step    <= DUTY_W'(1);
      rd_data <= '0;
      rd_hit  <= 1'b0;
    end else begin
      if (wren) begin
        for (int unsigned k = 0; k < NUM_CH; k++) begin
          if (ch_sel[k]) begin
            target[k] <= data[DUTY_W-1:0];
          end
        end
        if (step_sel) begin
          step <= data[DUTY_W-1:0];
        end
      end
      rd_hit  <= (|ch_sel) | step_sel | status_sel;
      rd_data <= '0;
      for (int unsigned k = 0; k < NUM_CH; k++) begin
        if (ch_sel[k]) begin
          rd_data <= 32'(live[k]);
        end
      end
      if (step_sel) begin
        rd_data <= 32'(step);
      end
      if (status_sel) begin
        rd_data <= 32'(busy);
      end
    end
  end

  always_comb begin
    duty_out = '0;
    busy     = '0;
    for (int unsigned k = 0; k < NUM_CH; k++) begin
      duty_out[k*DUTY_W +: DUTY_W] = live[k];
      busy[k]                      = (live[k] != target[k]);
    end
  end

endmodule

// File: tb/tb_servo_ramp_sequencer.sv
// Directed bench for servo_ramp_sequencer with a short tick period (TICK_DIV=4).
// After reset release, the tick counter wraps on every 4th clock edge.
// Channel k is therefore updated on the edge where ecount % 4 == k+1.
module tb_servo_ramp_sequencer;

  localparam int DW = 10;
  localparam int NC = 3;
  localparam int TD = 4;

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic              wren = 1'b0;
  logic [11:0]       address_dmem = '0;
  logic [31:0]       data = '0;
  logic [31:0]       rd_data;
  logic              rd_hit;
  logic [NC*DW-1:0]  duty_out;
  logic [NC-1:0]     busy;

  int n_tests = 0;
  int n_fail  = 0;
  int ecount  = 0;

  servo_ramp_sequencer #(
    .NUM_CH(NC),
    .DUTY_W(DW),
    .TICK_DIV(TD),
    .CH_BASE_ADDR(11),
    .STEP_ADDR(21),
    .STATUS_ADDR(22),
    .RESET_DUTY(0)
  ) dut (
    .clock(clock),
    .reset(reset),
    .wren(wren),
    .address_dmem(address_dmem),
    .data(data),
    .rd_data(rd_data),
    .rd_hit(rd_hit),
    .duty_out(duty_out),
    .busy(busy)
  );

  always #5 clock = ~clock;

  always @(posedge clock) if (!reset) ecount++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  function automatic logic [31:0] duty(input int ch);
    return 32'(duty_out[ch*DW +: DW]);
  endfunction

  function automatic int imin(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  // Called at a negedge; the store is sampled on the following posedge.
  task automatic write(input logic [11:0] a, input logic [31:0] d);
    wren = 1'b1;
    address_dmem = a;
    data = d;
    @(negedge clock);
    wren = 1'b0;
  endtask

  // Advance to the negedge just after channel ch's update edge.
  task automatic wait_upd(input int ch);
    int n = 0;
    do begin
      @(negedge clock);
      n++;
    end while ((ecount % TD) != ch + 1 && n < 2 * TD);
    if ((ecount % TD) != ch + 1) check("wait_upd_timeout", 32'(n), 32'(0));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset held across clock edges
    repeat (2) @(negedge clock);
    check("rst_duty", 32'(duty_out), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_rd_data", rd_data, 32'd0);
    check("rst_rd_hit", 32'(rd_hit), 32'd0);

    ecount = 0;
    reset = 1'b0;
    address_dmem = 12'd21;
    @(negedge clock);                       // e1
    check("rd_step_reset", rd_data, 32'd1);
    check("rd_step_hit", 32'(rd_hit), 32'd1);
    address_dmem = 12'd100;
    @(negedge clock);                       // e2
    check("rd_miss_hit", 32'(rd_hit), 32'd0);
    check("rd_miss_data", rd_data, 32'd0);

    // Ramp up, step 1, channel 0 to 10; address stays at 11 for read-back
    write(12'd11, 32'd10);                  // stored e3
    check("ramp_pre_duty", duty(0), 32'd0);
    check("ramp_pre_busy", 32'(busy), 32'b001);
    for (int i = 1; i <= 10; i++) begin
      wait_upd(0);
      check("ramp_duty0", duty(0), 32'(i));
      check("ramp_busy0", 32'(busy[0]), (i == 10) ? 32'd0 : 32'd1);
      check("ramp_rd_lag", rd_data, 32'(i - 1));
    end
    check("ramp_rd_hit", 32'(rd_hit), 32'd1);

    // Clamp with step 3 on channel 1: up 3,6,9,10 then down 7,4,1,0
    write(12'd21, 32'd3);
    write(12'd12, 32'd10);
    for (int i = 0; i < 4; i++) begin
      wait_upd(1);
      check("clamp_up", duty(1), 32'(imin(3 * (i + 1), 10)));
    end
    write(12'd12, 32'd0);
    for (int i = 0; i < 4; i++) begin
      wait_upd(1);
      check("clamp_dn", duty(1), (i == 3) ? 32'd0 : 32'(7 - 3 * i));
    end
    check("clamp_ch0_hold", duty(0), 32'd10);

    // Step 0: channel 2 jumps straight to 500 on wrap+3
    write(12'd21, 32'd0);
    write(12'd13, 32'd500);                 // stored on a wrap edge
    wait_upd(1);
    check("jump_pre", duty(2), 32'd0);
    check("jump_pre_busy", 32'(busy[2]), 32'd1);
    wait_upd(2);
    check("jump_post", duty(2), 32'd500);
    check("jump_busy", 32'(busy[2]), 32'd0);

    // Asynchronous reset mid-pass
    address_dmem = 12'd13;
    @(negedge clock);
    check("pre_rst_rd", rd_data, 32'd500);
    wait_upd(0);
    check("pre_rst_hit", 32'(rd_hit), 32'd1);
    #2 reset = 1'b1;
    #1;
    check("async_rst_duty", 32'(duty_out), 32'd0);
    check("async_rst_busy", 32'(busy), 32'd0);
    check("async_rst_rd", rd_data, 32'd0);
    check("async_rst_hit", 32'(rd_hit), 32'd0);
    repeat (2) @(negedge clock);
    address_dmem = 12'd21;
    ecount = 0;
    reset = 1'b0;
    @(negedge clock);                       // e1
    check("post_rst_step", rd_data, 32'd1);

    // Round-robin stagger: targets 5/6/7, step 1
    write(12'd11, 32'd5);                   // e2
    write(12'd12, 32'd6);                   // e3
    write(12'd13, 32'd7);                   // e4 (wrap)
    check("stag_pre", 32'(duty_out), 32'd0);
    check("stag_busy", 32'(busy), 32'b111);
    address_dmem = 12'd22;
    @(negedge clock);                       // e5
    check("stag_e5_ch0", duty(0), 32'd1);
    check("stag_e5_ch1", duty(1), 32'd0);
    check("stag_status", rd_data, 32'd7);
    @(negedge clock);                       // e6
    check("stag_e6_ch1", duty(1), 32'd1);
    check("stag_e6_ch2", duty(2), 32'd0);
    @(negedge clock);                       // e7
    check("stag_e7_ch2", duty(2), 32'd1);
    for (int t = 2; t <= 7; t++) begin
      wait_upd(2);
      check("stag_ch0", duty(0), 32'(imin(t, 5)));
      check("stag_ch1", duty(1), 32'(imin(t, 6)));
      check("stag_ch2", duty(2), 32'(t));
    end
    check("stag_done_busy", 32'(busy), 32'd0);
    @(negedge clock);
    check("stag_status_clr", rd_data, 32'd0);

    // Retarget collision on channel 1
    write(12'd12, 32'd20);                  // before ch1's slot in this pass
    wait_upd(1);
    check("retgt_up", duty(1), 32'd7);
    wait_upd(0);
    write(12'd12, 32'd0);                   // lands on ch1's update edge
    check("retgt_old", duty(1), 32'd8);
    check("retgt_busy", 32'(busy[1]), 32'd1);
    wait_upd(1);
    check("retgt_new", duty(1), 32'd7);

    // Full-scale step: no wrap in either direction; upper data bits ignored
    write(12'd21, 32'd1023);
    write(12'd11, 32'hABCD_FFFF);
    wait_upd(0);
    check("max_up", duty(0), 32'd1023);
    wait_upd(1);
    check("max_dn_floor", duty(1), 32'd0);
    write(12'd11, 32'd2);
    wait_upd(0);
    check("max_dn_clamp", duty(0), 32'd2);
    address_dmem = 12'd11;
    @(negedge clock);
    check("max_rd", rd_data, 32'd2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
